// File: rtl/tv_sequencer.sv
// Latency-aware vector test sequencer: streams {stim, expected} words
// from a synchronous ROM into a DUT and scores the delayed responses.
module tv_sequencer #(
   parameter int IN_W        = 8,
   parameter int OUT_W       = 8,
   parameter int ADDR_W      = 7,
   parameter int LATENCY     = 1,
   parameter int ERR_W       = 16,
   parameter int STOP_ON_ERR = 0
) (
   input  logic                    i_clk,
   input  logic                    i_reset_n,
   input  logic                    i_start,
   input  logic                    i_abort,
   input  logic [ADDR_W:0]         i_num_vectors,
   output logic                    o_mem_en,
   output logic [ADDR_W-1:0]       o_mem_addr,
   input  logic [IN_W+OUT_W-1:0]   i_mem_data,
   output logic [IN_W-1:0]         o_dut_in,
   input  logic [OUT_W-1:0]        i_dut_out,
   output logic                    o_busy,
   output logic                    o_done,
   output logic                    o_pass,
   output logic                    o_mismatch,
   output logic [ERR_W-1:0]        o_errors,
   output logic [ADDR_W-1:0]       o_first_fail,
   output logic [ADDR_W:0]         o_checked
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t            state;
   logic [ADDR_W:0]   n_q;
   logic [ADDR_W:0]   cnt_q;
   logic              rd_vld;
   logic [ADDR_W-1:0] rd_idx;

   // Stage 0 is loaded together with o_dut_in; stage LATENCY lines up
   // with the DUT response.
   logic [OUT_W-1:0]  p_exp [LATENCY+1];
   logic              p_vld [LATENCY+1];
   logic [ADDR_W-1:0] p_idx [LATENCY+1];

   logic cmp_vld;
   logic cmp_bad;
   logic last_cmp;
   logic stop;
   logic start_ok;

   assign o_busy     = (state == RUN) || (state == DRAIN);
   assign o_done     = (state == DONE);
   assign o_pass     = o_done && (o_errors == '0);
   assign o_mem_addr = cnt_q[ADDR_W-1:0];

   assign cmp_vld  = p_vld[LATENCY] && o_busy && !i_abort;
   assign cmp_bad  = cmp_vld && (i_dut_out != p_exp[LATENCY]);
   assign last_cmp = cmp_vld && ((o_checked + 1'b1) == n_q);
   assign stop     = cmp_bad && (STOP_ON_ERR != 0);
   assign start_ok = i_start && !i_abort &&
                     ((state == IDLE) || (state == DONE));

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state        <= IDLE;
         n_q          <= '0;
         cnt_q        <= '0;
         o_mem_en     <= 1'b0;
         rd_vld       <= 1'b0;
         rd_idx       <= '0;
         o_dut_in     <= '0;
         o_mismatch   <= 1'b0;
         o_errors     <= '0;
         o_first_fail <= '0;
         o_checked    <= '0;
         for (int j = 0; j <= LATENCY; j++) begin
            p_exp[j] <= '0;
            p_vld[j] <= 1'b0;
            p_idx[j] <= '0;
         end
      end else begin
         o_mismatch <= 1'b0;
         rd_vld     <= o_mem_en;
         rd_idx     <= o_mem_addr;
         if (rd_vld)
            o_dut_in <= i_mem_data[IN_W+OUT_W-1:OUT_W];
         p_exp[0] <= i_mem_data[OUT_W-1:0];
         p_vld[0] <= rd_vld;
         p_idx[0] <= rd_idx;
         for (int j = 1; j <= LATENCY; j++) begin
            p_exp[j] <= p_exp[j-1];
            p_vld[j] <= p_vld[j-1];
            p_idx[j] <= p_idx[j-1];
         end

         if (cmp_vld) begin
            o_checked <= o_checked + 1'b1;
            if (cmp_bad) begin
               o_mismatch <= 1'b1;
               if (o_errors != '1)
                  o_errors <= o_errors + 1'b1;
               if (o_errors == '0)
                  o_first_fail <= p_idx[LATENCY];
            end
         end

         unique case (state)
            IDLE, DONE: begin
               if (start_ok) begin
                  n_q          <= i_num_vectors;
                  cnt_q        <= '0;
                  o_errors     <= '0;
                  o_checked    <= '0;
                  o_first_fail <= '0;
                  if (i_num_vectors == '0) begin
                     state <= DONE;
                  end else begin
                     state    <= RUN;
                     o_mem_en <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (stop) begin
                  state <= DONE;
               end else if (cnt_q == n_q - 1'b1) begin
                  state    <= DRAIN;
                  o_mem_en <= 1'b0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            DRAIN: begin
               if (stop || last_cmp)
                  state <= DONE;
            end
         endcase

         // Early stop and abort both discard whatever is still in flight.
         if (stop || i_abort) begin
            o_mem_en <= 1'b0;
            rd_vld   <= 1'b0;
            for (int j = 0; j <= LATENCY; j++)
               p_vld[j] <= 1'b0;
         end
         if (i_abort) begin
            state      <= IDLE;
            o_mismatch <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_tv_sequencer.sv
// Directed bench for tv_sequencer: one registered-DUT instance and one
// combinational loopback instance with stop-on-error.
module tb_tv_sequencer;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        start_a = 0, abort_a = 0;
   logic [7:0]  n_a = '0;
   logic        en_a;
   logic [6:0]  addr_a;
   logic [15:0] mdat_a = '0;
   logic [7:0]  din_a;
   logic [7:0]  dout_a = '0;
   logic        busy_a, done_a, pass_a, mm_a;
   logic [1:0]  err_a;
   logic [6:0]  ff_a;
   logic [7:0]  chk_a;

   logic        start_b = 0, abort_b = 0;
   logic [7:0]  n_b = '0;
   logic        en_b;
   logic [6:0]  addr_b;
   logic [15:0] mdat_b = '0;
   logic [7:0]  din_b;
   logic [7:0]  dout_b;
   logic        busy_b, done_b, pass_b, mm_b;
   logic [15:0] err_b;
   logic [6:0]  ff_b;
   logic [7:0]  chk_b;

   logic [15:0] mem_a [128];
   logic [15:0] mem_b [128];

   always @(posedge clk) if (en_a) mdat_a <= mem_a[addr_a];
   always @(posedge clk) if (en_b) mdat_b <= mem_b[addr_b];
   always @(posedge clk) dout_a <= din_a;
   assign dout_b = din_b;

   tv_sequencer #(
      .IN_W(8), .OUT_W(8), .ADDR_W(7), .LATENCY(1),
      .ERR_W(2), .STOP_ON_ERR(0)
   ) u_a (
      .i_clk(clk), .i_reset_n(rst_n), .i_start(start_a),
      .i_abort(abort_a), .i_num_vectors(n_a), .o_mem_en(en_a),
      .o_mem_addr(addr_a), .i_mem_data(mdat_a), .o_dut_in(din_a),
      .i_dut_out(dout_a), .o_busy(busy_a), .o_done(done_a),
      .o_pass(pass_a), .o_mismatch(mm_a), .o_errors(err_a),
      .o_first_fail(ff_a), .o_checked(chk_a)
   );

   tv_sequencer #(
      .IN_W(8), .OUT_W(8), .ADDR_W(7), .LATENCY(0),
      .ERR_W(16), .STOP_ON_ERR(1)
   ) u_b (
      .i_clk(clk), .i_reset_n(rst_n), .i_start(start_b),
      .i_abort(abort_b), .i_num_vectors(n_b), .o_mem_en(en_b),
      .o_mem_addr(addr_b), .i_mem_data(mdat_b), .o_dut_in(din_b),
      .i_dut_out(dout_b), .o_busy(busy_b), .o_done(done_b),
      .o_pass(pass_b), .o_mismatch(mm_b), .o_errors(err_b),
      .o_first_fail(ff_b), .o_checked(chk_b)
   );

   typedef struct {
      int          sel;
      int          n;
      logic [127:0] bad;
      int          cyc;
      int          errs;
      int          chk;
      int          ff;
      int          pass;
      int          pulses;
      int          ens;
   } vec_t;

   vec_t tbl [9];
   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic run(input vec_t v);
      int cyc, ens, pls;
      logic [7:0] b;
      for (int i = 0; i < 128; i++) begin
         b = i[7:0];
         if (v.sel == 0) mem_a[i] = {b, v.bad[i] ? ~b : b};
         else            mem_b[i] = {b, v.bad[i] ? ~b : b};
      end
      @(negedge clk);
      if (v.sel == 0) begin start_a = 1; n_a = 8'(v.n); end
      else            begin start_b = 1; n_b = 8'(v.n); end
      @(posedge clk); #1;
      start_a = 0; start_b = 0;
      cyc = 0; ens = 0; pls = 0;
      while (1) begin
         ens += int'(v.sel == 0 ? en_a : en_b);
         pls += int'(v.sel == 0 ? mm_a : mm_b);
         if ((v.sel == 0 ? done_a : done_b) || cyc >= 400) break;
         @(posedge clk); #1;
         cyc++;
      end
      check("cycles", cyc, v.cyc);
      check("errors", v.sel == 0 ? int'(err_a) : int'(err_b), v.errs);
      check("checked", v.sel == 0 ? int'(chk_a) : int'(chk_b), v.chk);
      check("first_fail", v.sel == 0 ? int'(ff_a) : int'(ff_b), v.ff);
      check("pass", int'(v.sel == 0 ? pass_a : pass_b), v.pass);
      check("pulses", pls, v.pulses);
      check("mem_en", ens, v.ens);
   endtask

   initial begin
      int k;
      vec_t h;
      //         sel n    bad                           cyc er ck  ff  ps pl en
      tbl[0] = '{0, 8,   128'(1) << 5,                 11, 1, 8,  5,  0, 1, 8};
      tbl[1] = '{0, 4,   128'(0),                      7,  0, 4,  0,  1, 0, 4};
      tbl[2] = '{0, 10,  128'h256,                     13, 3, 10, 1,  0, 5, 10};
      tbl[3] = '{0, 0,   128'(0),                      0,  0, 0,  0,  1, 0, 0};
      tbl[4] = '{0, 1,   128'(1),                      4,  1, 1,  0,  0, 1, 1};
      tbl[5] = '{0, 128, 128'(1) << 127,               131, 1, 128, 127, 0, 1, 128};
      tbl[6] = '{1, 4,   128'(0),                      6,  0, 4,  0,  1, 0, 4};
      tbl[7] = '{1, 10,  (128'(1) << 3) | (128'(1) << 7), 6, 1, 4, 3, 0, 1, 6};
      tbl[8] = '{1, 2,   128'(0),                      4,  0, 2,  0,  1, 0, 2};

      repeat (3) @(posedge clk);
      #1;
      check("reset_a", int'(|{busy_a, done_a, pass_a, mm_a, en_a, addr_a,
                              din_a, err_a, ff_a, chk_a}), 0);
      check("reset_b", int'(|{busy_b, done_b, pass_b, mm_b, en_b, addr_b,
                              din_b, err_b, ff_b, chk_b}), 0);
      @(negedge clk);
      rst_n = 1;

      for (int i = 0; i < 9; i++) run(tbl[i]);

      // Abort while the third address is being issued.
      @(negedge clk);
      start_a = 1; n_a = 8;
      @(posedge clk); #1;
      start_a = 0;
      k = 0;
      while (addr_a != 7'd2 && k < 20) begin
         @(posedge clk); #1;
         k++;
      end
      check("abort_reach", k, 2);
      abort_a = 1;
      @(posedge clk); #1;
      abort_a = 0;
      check("abort_busy", int'(busy_a), 0);
      check("abort_mem_en", int'(en_a), 0);
      check("abort_done", int'(done_a), 0);
      @(posedge clk); #1;
      check("abort_idle_en", int'(en_a), 0);
      h = '{0, 3, 128'(0), 6, 0, 3, 0, 1, 0, 3};
      run(h);

      // Asynchronous reset while draining, with results already non-zero.
      mem_a[0] = 16'h00FF;
      @(negedge clk);
      start_a = 1; n_a = 4;
      @(posedge clk); #1;
      start_a = 0;
      k = 0;
      while (!(busy_a && !en_a) && k < 20) begin
         @(posedge clk); #1;
         k++;
      end
      check("drain_reach", k, 4);
      check("drain_errors", int'(err_a), 1);
      #2 rst_n = 0;
      #1;
      check("drain_reset", int'(|{busy_a, done_a, pass_a, mm_a, en_a,
                                   addr_a, din_a, err_a, ff_a, chk_a}), 0);
      #2 rst_n = 1;
      @(posedge clk); #1;
      check("post_reset_busy", int'(busy_a), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
